// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer state encoding, special instruction words and default widths.
package cpu_pkg;

  localparam int unsigned PC_W_DEF  = 32;
  localparam int unsigned INST_W    = 32;
  localparam int unsigned STATE_W   = 2;

  localparam logic [INST_W-1:0] HALT_INST_DEF = 32'h0000_0000;
  localparam logic [INST_W-1:0] NOP_INST      = 32'h0000_0013;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_RUN    = 2'd1;
  localparam state_t S_STEP   = 2'd2;
  localparam state_t S_HALTED = 2'd3;

  // True for the states in which instructions execute and the divider counts.
  function automatic logic is_exec(input state_t st);
    return (st == S_RUN) || (st == S_STEP);
  endfunction

endpackage

// File: rtl/pc_sequencer_tick_gen.sv
// Clock-enable divider: tick is high for one cycle out of every DIV enabled cycles.
module tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Tick is a combinational enable so the consumer acts on the same edge the counter wraps.
  assign tick = en && (cnt == LAST);

  // Divider counter: cleared on (re)entry, advances only while enabled, wraps at DIV-1.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/commit sequencer: owns the PC, runs/steps/halts the core on divided execute ticks,
// and counts retired instructions. Optional breakpoint compare under PCSEQ_BREAKPOINT_EN.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned          PC_W      = PC_W_DEF,
  parameter int unsigned          DIV       = 4,
  parameter logic [PC_W-1:0]      RESET_PC  = '0,
  parameter logic [INST_W-1:0]    HALT_INST = HALT_INST_DEF,
  parameter int unsigned          CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_req,
  input  logic              stop_req,
  input  logic              step_req,
  input  logic [INST_W-1:0] inst,
  input  logic [PC_W-1:0]   npc,
  output logic [PC_W-1:0]   pc,
  output logic              commit,
  output logic              halted,
  output logic              running,
`ifdef PCSEQ_BREAKPOINT_EN
  input  logic              bp_en,
  input  logic [PC_W-1:0]   bp_addr,
  output logic              bp_hit,
`endif
  output logic [CNT_W-1:0]  retired
);

  state_t state;
  state_t state_nxt;
  logic   tick;
  logic   exec_c;
  logic   clr_c;
  logic   commit_c;
  logic   is_halt_c;
  logic   bp_stop_c;
  logic   bp_hit_c;

  assign exec_c    = is_exec(state);
  assign is_halt_c = (inst == HALT_INST);

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_c),
    .en   (exec_c),
    .tick (tick)
  );

`ifdef PCSEQ_BREAKPOINT_EN
  logic bp_armed;

  // Breakpoint arms after the first tick following a resume, so a resumed core can leave bp_addr.
  always_ff @(posedge clk) begin
    if (rst || clr_c) begin
      bp_armed <= 1'b0;
    end else if (tick) begin
      bp_armed <= 1'b1;
    end
  end

  assign bp_stop_c = bp_en && bp_armed && (pc == bp_addr);
`else
  assign bp_stop_c = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and commit decode; stop beats run beats step, HALT beats breakpoint.
  always_comb begin
    state_nxt = state;
    clr_c     = 1'b0;
    commit_c  = 1'b0;
    bp_hit_c  = 1'b0;
    case (state)
      S_IDLE: begin
        if (stop_req) begin
          state_nxt = S_IDLE;
        end else if (run_req) begin
          state_nxt = S_RUN;
          clr_c     = 1'b1;
        end else if (step_req) begin
          state_nxt = S_STEP;
          clr_c     = 1'b1;
        end
      end
      S_RUN: begin
        if (stop_req) begin
          state_nxt = S_IDLE;
        end else if (tick) begin
          if (is_halt_c) begin
            state_nxt = S_HALTED;
          end else if (bp_stop_c) begin
            state_nxt = S_IDLE;
            bp_hit_c  = 1'b1;
          end else begin
            commit_c  = 1'b1;
          end
        end
      end
      S_STEP: begin
        if (stop_req) begin
          state_nxt = S_IDLE;
        end else if (tick) begin
          if (is_halt_c) begin
            state_nxt = S_HALTED;
          end else begin
            commit_c  = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      S_HALTED: begin
        state_nxt = S_HALTED;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // PC update, commit pulse and saturating retired counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      commit  <= 1'b0;
      retired <= '0;
    end else begin
      commit <= commit_c;
      if (commit_c) begin
        pc <= npc;
        if (retired != {CNT_W{1'b1}}) begin
          retired <= retired + CNT_W'(1);
        end
      end
    end
  end

  // Status flags track the state register on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      halted  <= 1'b0;
    end else begin
      running <= is_exec(state_nxt);
      halted  <= (state_nxt == S_HALTED);
    end
  end

`ifdef PCSEQ_BREAKPOINT_EN
  // One-cycle breakpoint hit pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      bp_hit <= 1'b0;
    end else begin
      bp_hit <= bp_hit_c;
    end
  end
`else
  logic unused_bp_c;
  assign unused_bp_c = bp_hit_c;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (DIV=4, PC_W=16, CNT_W=4). Breakpoint scenario under PCSEQ_BREAKPOINT_EN.
module tb_pc_sequencer;

  localparam logic [31:0] HALT_W = 32'h0000_0000;
  localparam logic [31:0] ADD_W  = 32'h0020_81B3;

  logic        clk;
  logic        rst;
  logic        run_req;
  logic        stop_req;
  logic        step_req;
  logic [31:0] inst;
  logic [15:0] npc;
  logic [15:0] pc;
  logic        commit;
  logic        halted;
  logic        running;
  logic [3:0]  retired;
  logic [15:0] halt_pc;
`ifdef PCSEQ_BREAKPOINT_EN
  logic        bp_en;
  logic [15:0] bp_addr;
  logic        bp_hit;
`endif

  int checks;
  int errors;

  pc_sequencer #(
    .PC_W      (16),
    .DIV       (4),
    .RESET_PC  (16'h0000),
    .HALT_INST (32'h0000_0000),
    .CNT_W     (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .run_req  (run_req),
    .stop_req (stop_req),
    .step_req (step_req),
    .inst     (inst),
    .npc      (npc),
    .pc       (pc),
    .commit   (commit),
    .halted   (halted),
    .running  (running),
`ifdef PCSEQ_BREAKPOINT_EN
    .bp_en    (bp_en),
    .bp_addr  (bp_addr),
    .bp_hit   (bp_hit),
`endif
    .retired  (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program memory: HALT at halt_pc, ADD elsewhere; executor yields pc+1.
  always_comb begin
    inst = (pc == halt_pc) ? HALT_W : ADD_W;
    npc  = pc + 16'd1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) cyc();
    checks++; if (pc !== 16'h0) begin errors++; $display("FAIL reset_pc got %0h expected 0", pc); end
    checks++; if (commit !== 1'b0) begin errors++; $display("FAIL reset_commit got %0b expected 0", commit); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %0b expected 0", halted); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %0b expected 0", running); end
    checks++; if (retired !== 4'h0) begin errors++; $display("FAIL reset_retired got %0h expected 0", retired); end
    rst = 1'b0;
  endtask

  task automatic test_run_halt();
    int first, second, n_commit, halt_at;
    logic late_commit;
    first = -1; second = -1; n_commit = 0; halt_at = -1; late_commit = 1'b0;
    halt_pc = 16'd2;
    run_req = 1'b1;
    cyc();
    run_req = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      cyc();
      if (commit === 1'b1) begin
        if (n_commit == 0) first = n;
        else if (n_commit == 1) second = n;
        n_commit++;
      end
      if (halted === 1'b1 && halt_at < 0) halt_at = n;
    end
    checks++; if (first != 4) begin errors++; $display("FAIL run_first_commit got cycle %0d expected 4", first); end
    checks++; if (second != 8) begin errors++; $display("FAIL run_second_commit got cycle %0d expected 8", second); end
    checks++; if (n_commit != 2) begin errors++; $display("FAIL run_commit_count got %0d expected 2", n_commit); end
    checks++; if (halt_at != 12) begin errors++; $display("FAIL run_halt_cycle got %0d expected 12", halt_at); end
    checks++; if (pc !== 16'd2) begin errors++; $display("FAIL run_halt_pc got %0h expected 2", pc); end
    checks++; if (retired !== 4'd2) begin errors++; $display("FAIL run_retired got %0d expected 2", retired); end
    for (int n = 0; n < 10; n++) begin
      cyc();
      if (commit === 1'b1) late_commit = 1'b1;
    end
    checks++; if (late_commit !== 1'b0) begin errors++; $display("FAIL halt_no_commit got %0b expected 0", late_commit); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL halt_running got %0b expected 0", running); end
  endtask

  task automatic test_halted_sticky();
    logic left;
    left = 1'b0;
    run_req = 1'b1;
    step_req = 1'b1;
    repeat (6) begin
      cyc();
      if (halted !== 1'b1 || commit !== 1'b0) left = 1'b1;
    end
    run_req = 1'b0;
    step_req = 1'b0;
    checks++; if (left !== 1'b0) begin errors++; $display("FAIL halted_sticky got left=%0b expected 0", left); end
    checks++; if (pc !== 16'd2) begin errors++; $display("FAIL halted_pc got %0h expected 2", pc); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++; if (pc !== 16'h0) begin errors++; $display("FAIL rst_pc got %0h expected 0", pc); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %0b expected 0", halted); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL rst_running got %0b expected 0", running); end
    checks++; if (retired !== 4'h0) begin errors++; $display("FAIL rst_retired got %0h expected 0", retired); end
  endtask

  task automatic test_step();
    logic found;
    int first, n_commit;
    found = 1'b0; first = -1; n_commit = 0;
    halt_pc = 16'hFFFF;
    run_req = 1'b1;
    cyc();
    run_req = 1'b0;
    for (int n = 0; n < 40; n++) begin
      cyc();
      if (pc === 16'd5) begin found = 1'b1; break; end
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL step_setup_reach_pc5 got pc %0h expected 5", pc); end
    stop_req = 1'b1;
    cyc();
    stop_req = 1'b0;
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL step_setup_idle got running %0b expected 0", running); end
    checks++; if (pc !== 16'd5) begin errors++; $display("FAIL step_setup_pc got %0h expected 5", pc); end
    step_req = 1'b1;
    cyc();
    step_req = 1'b0;
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL step_running got %0b expected 1", running); end
    for (int n = 1; n <= 8; n++) begin
      cyc();
      if (commit === 1'b1) begin
        if (n_commit == 0) first = n;
        n_commit++;
      end
    end
    checks++; if (n_commit != 1) begin errors++; $display("FAIL step_commit_count got %0d expected 1", n_commit); end
    checks++; if (first != 4) begin errors++; $display("FAIL step_commit_cycle got %0d expected 4", first); end
    checks++; if (pc !== 16'd6) begin errors++; $display("FAIL step_pc got %0h expected 6", pc); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL step_running_after got %0b expected 0", running); end
    checks++; if (retired !== 4'd6) begin errors++; $display("FAIL step_retired got %0d expected 6", retired); end
  endtask

  task automatic test_stop_on_tick();
    logic seen;
    seen = 1'b0;
    run_req = 1'b1;
    cyc();
    run_req = 1'b0;
    repeat (3) begin
      cyc();
      if (commit === 1'b1) seen = 1'b1;
    end
    stop_req = 1'b1;
    cyc();
    stop_req = 1'b0;
    if (commit === 1'b1) seen = 1'b1;
    repeat (5) begin
      cyc();
      if (commit === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL stop_tick_commit got %0b expected 0", seen); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL stop_tick_running got %0b expected 0", running); end
    checks++; if (pc !== 16'd6) begin errors++; $display("FAIL stop_tick_pc got %0h expected 6", pc); end
    checks++; if (retired !== 4'd6) begin errors++; $display("FAIL stop_tick_retired got %0d expected 6", retired); end
  endtask

  task automatic test_saturate();
    int n_commit;
    logic [3:0] exp_ret;
    n_commit = 0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    halt_pc = 16'hFFFF;
    run_req = 1'b1;
    cyc();
    run_req = 1'b0;
    for (int n = 0; n < 90; n++) begin
      cyc();
      if (commit === 1'b1) begin
        n_commit++;
        exp_ret = (n_commit >= 15) ? 4'hF : 4'(n_commit);
        checks++;
        if (retired !== exp_ret) begin
          errors++; $display("FAIL sat_retired_at_%0d got %0h expected %0h", n_commit, retired, exp_ret);
        end
        if (n_commit == 18) break;
      end
    end
    stop_req = 1'b1;
    cyc();
    stop_req = 1'b0;
    checks++; if (n_commit != 18) begin errors++; $display("FAIL sat_commit_count got %0d expected 18", n_commit); end
    checks++; if (retired !== 4'hF) begin errors++; $display("FAIL sat_final got %0h expected f", retired); end
    checks++; if (pc !== 16'd18) begin errors++; $display("FAIL sat_pc got %0d expected 18", pc); end
  endtask

`ifdef PCSEQ_BREAKPOINT_EN
  task automatic test_breakpoint();
    int hit_at, n_commit, first;
    logic hit2;
    hit_at = -1; n_commit = 0; first = -1; hit2 = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    halt_pc = 16'hFFFF;
    bp_en = 1'b1;
    bp_addr = 16'd3;
    run_req = 1'b1;
    cyc();
    run_req = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      cyc();
      if (commit === 1'b1) n_commit++;
      if (bp_hit === 1'b1) begin hit_at = n; break; end
    end
    checks++; if (hit_at != 16) begin errors++; $display("FAIL bp_hit_cycle got %0d expected 16", hit_at); end
    checks++; if (pc !== 16'd3) begin errors++; $display("FAIL bp_pc got %0h expected 3", pc); end
    checks++; if (commit !== 1'b0) begin errors++; $display("FAIL bp_commit got %0b expected 0", commit); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL bp_running got %0b expected 0", running); end
    checks++; if (n_commit != 3) begin errors++; $display("FAIL bp_commit_count got %0d expected 3", n_commit); end
    cyc();
    checks++; if (bp_hit !== 1'b0) begin errors++; $display("FAIL bp_hit_pulse got %0b expected 0", bp_hit); end
    run_req = 1'b1;
    cyc();
    run_req = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      cyc();
      if (commit === 1'b1 && first < 0) first = n;
      if (bp_hit === 1'b1) hit2 = 1'b1;
    end
    stop_req = 1'b1;
    cyc();
    stop_req = 1'b0;
    checks++; if (first != 4) begin errors++; $display("FAIL bp_resume_commit got cycle %0d expected 4", first); end
    checks++; if (hit2 !== 1'b0) begin errors++; $display("FAIL bp_resume_hit got %0b expected 0", hit2); end
    checks++; if (pc !== 16'd4) begin errors++; $display("FAIL bp_resume_pc got %0h expected 4", pc); end
    bp_en = 1'b0;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    run_req = 1'b0;
    stop_req = 1'b0;
    step_req = 1'b0;
    halt_pc = 16'd2;
`ifdef PCSEQ_BREAKPOINT_EN
    bp_en = 1'b0;
    bp_addr = 16'h0;
`endif
    test_reset();
    test_run_halt();
    test_halted_sticky();
    test_step();
    test_stop_on_tick();
    test_saturate();
`ifdef PCSEQ_BREAKPOINT_EN
    test_breakpoint();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
